// File: rtl/key_event_capture.sv
// Eight-channel request front end: two-flop synchroniser, per-channel debounce,
// sticky pending/overrun flags on debounced rising edges, acknowledged by index.
module key_event_capture #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] btn,
  input  logic       ack,
  input  logic [2:0] ack_idx,
  output logic [7:0] stable,
  output logic [7:0] pend,
  output logic [7:0] ovr,
  output logic       irq
);

  localparam logic [7:0] CNT_MAX = 8'(DEB_CYCLES - 1);

  logic [7:0]       s1_q, s2_q;
  logic [7:0][7:0]  cnt_q, cnt_d;
  logic [7:0]       stable_q, stable_d;
  logic [7:0]       pend_q, pend_d;
  logic [7:0]       ovr_q, ovr_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves a latch.
    cnt_d    = cnt_q;
    stable_d = stable_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    for (int k = 0; k < 8; k++) begin
      logic accept, rise, clr;
      accept = (s2_q[k] != stable_q[k]) && (cnt_q[k] == CNT_MAX);
      // Rise comes straight from the accept so the event lands with the level.
      rise   = accept && s2_q[k];
      clr    = ack && (ack_idx == 3'(k));

      if (s2_q[k] == stable_q[k]) begin
        cnt_d[k] = '0;
      end else if (accept) begin
        stable_d[k] = s2_q[k];
        cnt_d[k]    = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + 8'd1;
      end

      if (rise && clr) begin
        pend_d[k] = 1'b1;
        ovr_d[k]  = 1'b0;
      end else if (rise) begin
        pend_d[k] = 1'b1;
        if (pend_q[k]) ovr_d[k] = 1'b1;
      end else if (clr) begin
        pend_d[k] = 1'b0;
        ovr_d[k]  = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the counters are
  // few enough to reset, which makes reset-release latency deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      pend_q   <= '0;
      ovr_q    <= '0;
    end else begin
      s1_q     <= btn;
      s2_q     <= s1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
    end
  end

  assign stable = stable_q;
  assign pend   = pend_q;
  assign ovr    = ovr_q;
  assign irq    = |pend_q;

endmodule

// File: doc/key_event_capture.md
# key_event_capture

Eight-channel input front end that synchronises and debounces raw request lines and latches each debounced rising edge into a sticky pending vector. It sits directly upstream of the 8-to-3 priority encoder: `pend` drives the encoder's 8-bit input, and the downstream consumer acknowledges the serviced channel by index. Lost events (a new rise on an already-pending channel) are flagged per channel.

## Interface
- `DEB_CYCLES`, default 4: consecutive cycles the synchronised input must differ from the debounced level before the level is accepted; legal range 1..255.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn`  in  8  raw, asynchronous request lines; bit k is channel k.
- `ack`  in  1  acknowledge strobe, one cycle per acknowledged event.
- `ack_idx`  in  3  channel index being acknowledged; sampled only when `ack`=1.
- `stable`  out  8  debounced level per channel.
- `pend`  out  8  sticky pending-event vector; feeds the priority encoder.
- `ovr`  out  8  sticky per-channel overrun (event lost) flag.
- `irq`  out  1  OR of `pend`; combinational from the `pend` register.

## Operation
- Synchroniser: two flops per channel, `btn` -> s1 -> s2; only s2 is used downstream.
- Debounce, per channel, 8-bit counter:
  - s2 == `stable[k]`: counter <= 0.
  - s2 != `stable[k]` and counter < DEB_CYCLES-1: counter increments.
  - s2 != `stable[k]` and counter == DEB_CYCLES-1: `stable[k]` <= s2, counter <= 0 (accept).
  - A pulse or glitch shorter than DEB_CYCLES cycles at s2 never changes `stable`.
- Event detection: an accept that takes `stable[k]` from 0 to 1 is a rise. The rise is detected from the accept condition in the same cycle, not from a delayed copy. Falling accepts generate no event.
- Pending/ack, per channel k; clr = `ack` && `ack_idx`==k:
  - rise, no clr: `pend[k]` <= 1; if `pend[k]` was already 1, `ovr[k]` <= 1.
  - clr, no rise: `pend[k]` <= 0, `ovr[k]` <= 0.
  - rise and clr in the same cycle: `pend[k]` stays 1 (new event); `ovr[k]` <= 0.
  - clr with `pend[k]`=0: no effect.
  - Only one channel is cleared per ack; all other channels are unaffected.
- `irq` = |`pend`.

## Timing
- Reset values: `stable`, `pend`, `ovr` = 8'h00; `irq`=0; synchroniser flops and counters = 0.
- Latency: if `btn[k]` rises before edge 1 and holds, `stable[k]` and `pend[k]` are both 1 after edge 2+DEB_CYCLES. This is edge 6 for DEB_CYCLES=4 and edge 3 for DEB_CYCLES=1.
- Release follows the same path: `stable[k]` falls DEB_CYCLES+2 edges after `btn[k]` falls; `pend` is unaffected.
- Ack: `pend[k]` and `irq` update on the edge that samples `ack`=1; visible next cycle.
- Reset mid-operation clears all state immediately, including pending and overrun flags. Lines held high through reset release are re-reported as new rises DEB_CYCLES+2 edges after reset release.
- Any number of channels may rise on the same edge; all are latched.

## Test plan
- Reset, then `btn`=8'h04 held (DEB_CYCLES=4) -> `stable`=8'h04, `pend`=8'h04, `irq`=1 exactly 6 edges after the first sampling edge; nothing earlier.
- `btn[0]` pulsed high for 3 cycles (DEB_CYCLES=4) -> `stable`, `pend` remain 8'h00 throughout.
- `btn`=8'h81 rising together -> `pend`=8'h81. `ack`=1, `ack_idx`=7 -> `pend`=8'h01, `irq`=1. `ack`, `ack_idx`=0 -> `pend`=8'h00, `irq`=0.
- Channel 3 rise, release, rise again without ack -> `pend[3]`=1, `ovr[3]`=1. Ack index 3 -> both 0.
- Ack index 5 on the same edge as a channel-5 rise accept -> `pend[5]`=1, `ovr[5]`=0. Ack index 2 while `pend[2]`=0 -> no change.
- `pend`=8'hFF, assert `rst_n`=0 between edges -> all outputs 0 immediately. `btn`=8'hFF held through release -> `pend`=8'hFF again after 6 edges.
